// File: rtl/stream_fifo.sv
// Elastic stb/ack buffer of DEPTH words between an arbiter and a slower consumer.
// All outputs come from registered state; only rst gates the handshakes.
module stream_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     input_a,
    input  logic                 input_a_stb,
    output logic                 input_a_ack,
    output logic [WIDTH-1:0]     output_z,
    output logic                 output_z_stb,
    input  logic                 output_z_ack,
    output logic [ADDR_BITS:0]   count
);

    localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    // Handshake: a word moves on a rising edge where stb and ack are both 1 on
    // that port; senders hold stb and data stable until that edge.

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 push;
    logic                 pop;

    assign input_a_ack  = (count != CNT_FULL) && !rst;
    assign output_z_stb = (count != '0) && !rst;
    assign output_z     = (count != '0) ? mem[rd_ptr] : '0;

    assign push = input_a_stb & input_a_ack;
    assign pop  = output_z_stb & output_z_ack;

    // Storage is not reset; stale words are hidden because output_z is gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= input_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule
